// File: rtl/top_level_dec_if.sv
// top_level_dec_if: request/response bundle for the RSA decryption core.
//   start  - one-cycle request (master -> core)
//   c      - ciphertext          (master -> core)
//   d_key  - private exponent    (master -> core)
//   n      - modulus             (master -> core)
//   m      - plaintext, held until the next done (core -> master)
//   done   - one-cycle completion pulse          (core -> master)
//   busy   - operation in flight                 (core -> master)
interface top_level_dec_if #(
  parameter int WIDTH = 128
);
  logic             start;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d_key;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] m;
  logic             done;
  logic             busy;

  modport master (output start, c, d_key, n, input m, done, busy);
  modport slave  (input start, c, d_key, n, output m, done, busy);
endinterface

// File: rtl/top_level_dec.sv
// top_level_dec: constant-time RSA decryption core, m = c^d mod n.
// Right-to-left square-and-multiply; every modular product is an
// interleaved shift-add reduction consuming one multiplier bit per clock.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset, clears all state
//   bus   - slave side of top_level_dec_if (start/c/d_key/n in, m/done/busy out)
module top_level_dec #(
  parameter int WIDTH = 128
) (
  input  logic            clk,
  input  logic            reset,
  top_level_dec_if.slave  bus
);
  localparam int AW = WIDTH + 2;          // holds 2n-1 without overflow
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_MUL, S_SQR, S_NEXT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d, d_q, d_d, n_q, n_d;
  logic [WIDTH-1:0] base_q, base_d, result_q, result_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    k_q, k_d, i_q, i_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             done_q, done_d, busy_q, busy_d;

  logic [WIDTH-1:0] op_a;
  logic             op_b;
  logic [AW-1:0]    step;

  // One iteration of the interleaved modular multiply: acc = (2*acc + b*a) mod n,
  // with both partial sums kept below n by a single conditional subtract.
  function automatic logic [AW-1:0] mm_step(input logic [AW-1:0] acc,
                                            input logic [WIDTH-1:0] a,
                                            input logic bbit,
                                            input logic [WIDTH-1:0] modn);
    logic [AW-1:0] t, nn;
    nn = {2'b00, modn};
    t  = {acc[AW-2:0], 1'b0};
    if (t >= nn) t = t - nn;
    if (bbit) t = t + {2'b00, a};
    if (t >= nn) t = t - nn;
    return t;
  endfunction

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    d_d      = d_q;
    n_d      = n_q;
    base_d   = base_q;
    result_d = result_q;
    acc_d    = acc_q;
    k_d      = k_q;
    i_d      = i_q;
    m_d      = m_q;
    done_d   = 1'b0;
    busy_d   = busy_q;

    // Operand selection for the shared modular multiplier.
    op_a = '0;
    op_b = 1'b0;
    case (state_q)
      S_REDUCE: begin op_a = WIDTH'(1); op_b = c_q[k_q];    end
      S_MUL:    begin op_a = result_q;  op_b = base_q[k_q]; end
      S_SQR:    begin op_a = base_q;    op_b = base_q[k_q]; end
      default:  ;
    endcase
    // A zero modulus bypasses the product datapath; the timing is unchanged.
    step = (n_q == '0) ? '0 : mm_step(acc_q, op_a, op_b, n_q);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          c_d      = bus.c;
          d_d      = bus.d_key;
          n_d      = bus.n;
          result_d = WIDTH'(1);
          i_d      = '0;
          k_d      = LAST;
          acc_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_REDUCE;
        end
      end
      S_REDUCE, S_MUL, S_SQR: begin
        acc_d = step;
        k_d   = k_q - 1'b1;
        if (k_q == '0) begin
          acc_d = '0;
          k_d   = LAST;
          case (state_q)
            S_REDUCE: begin base_d = step[WIDTH-1:0]; state_d = S_MUL; end
            // The product is always formed; only its use depends on the key bit.
            S_MUL: begin
              if (d_q[i_q]) result_d = step[WIDTH-1:0];
              state_d = S_SQR;
            end
            default: begin base_d = step[WIDTH-1:0]; state_d = S_NEXT; end
          endcase
        end
      end
      S_NEXT: begin
        if (i_q == LAST) state_d = S_DONE;
        else begin
          i_d     = i_q + 1'b1;
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        // Moduli 0 and 1 have no valid residue other than 0.
        m_d     = (n_q > WIDTH'(1)) ? result_q : '0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      d_q      <= '0;
      n_q      <= '0;
      base_q   <= '0;
      result_q <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      i_q      <= '0;
      m_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      d_q      <= d_d;
      n_q      <= n_d;
      base_q   <= base_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      i_q      <= i_d;
      m_q      <= m_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.m    = m_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_top_level_dec.sv
// tb_top_level_dec: directed and randomized checks of top_level_dec.
// A 128-bit instance runs the long key-pair, abort and recovery cases while a
// 16-bit instance runs directed, boundary, re-trigger and random cases in parallel.
module tb_top_level_dec;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  top_level_dec_if #(.WIDTH(128)) a_if();
  top_level_dec_if #(.WIDTH(16))  b_if();

  top_level_dec #(.WIDTH(128)) u_a (.clk(clk), .reset(rst_a), .bus(a_if.slave));
  top_level_dec #(.WIDTH(16))  u_b (.clk(clk), .reset(rst_b), .bus(b_if.slave));

  localparam int LA = 128 + 128 * (2 * 128 + 1) + 2;  // 33026
  localparam int LB = 16 + 16 * (2 * 16 + 1) + 2;     // 546

  int vecs = 0;
  int errs = 0;

  // Reference: c^d mod n by plain modular exponentiation on integers.
  function automatic longint unsigned modpow(input longint unsigned b,
                                             input longint unsigned e,
                                             input longint unsigned md);
    longint unsigned r;
    if (md < 2) return 0;
    r = 1;
    b = b % md;
    while (e != 0) begin
      if ((e & 1) != 0) r = (r * b) % md;
      b = (b * b) % md;
      e = e >> 1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 128-bit run; abort_at >= 0 pulls reset low at that cycle of the run.
  task automatic op128(input longint unsigned cv, input longint unsigned dv,
                       input longint unsigned nv, input string tag, input int abort_at);
    longint unsigned exp;
    int cyc, busy_bad, extra;
    exp = modpow(cv, dv, nv);
    @(negedge clk);
    a_if.c = 128'(cv); a_if.d_key = 128'(dv); a_if.n = 128'(nv); a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    cyc = 0; busy_bad = 0;
    while (!a_if.done && cyc < LA + 10) begin
      if (!a_if.busy) busy_bad++;
      if (abort_at >= 0 && cyc == abort_at) begin
        rst_a = 1'b0;
        #1;
        chk({tag, "_m0"}, a_if.m, 128'd0);
        chk({tag, "_busy0"}, 128'(a_if.busy), 128'd0);
        chk({tag, "_done0"}, 128'(a_if.done), 128'd0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        extra = 0;
        repeat (100) begin
          @(negedge clk);
          if (a_if.done || a_if.busy) extra++;
        end
        chk({tag, "_quiet"}, 128'(extra), 128'd0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    // done was set by edge cyc; the next rising edge is the one that samples it high.
    chk({tag, "_lat"}, 128'(cyc + 1), 128'(LA));
    chk({tag, "_m"}, a_if.m, 128'(exp));
    chk({tag, "_busy_at_done"}, 128'(a_if.busy), 128'd0);
    chk({tag, "_busy_run"}, 128'(busy_bad), 128'd0);
    @(negedge clk);
    chk({tag, "_done_width"}, 128'(a_if.done), 128'd0);
  endtask

  // 16-bit run; mode 1 re-pulses start at cycle 100, mode 2 scrambles inputs at cycle 50.
  task automatic op16(input logic [15:0] cv, input logic [15:0] dv, input logic [15:0] nv,
                      input int mode, input string tag);
    longint unsigned exp;
    int cyc, busy_bad, extra, moved;
    exp = modpow(64'(cv), 64'(dv), 64'(nv));
    @(negedge clk);
    b_if.c = cv; b_if.d_key = dv; b_if.n = nv; b_if.start = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    cyc = 0; busy_bad = 0;
    while (!b_if.done && cyc < LB + 10) begin
      if (!b_if.busy) busy_bad++;
      b_if.start = (mode == 1 && cyc == 100);
      if (mode == 2 && cyc == 50) begin
        b_if.c = 16'($urandom); b_if.d_key = 16'($urandom); b_if.n = 16'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    b_if.start = 1'b0;
    chk({tag, "_lat"}, 128'(cyc + 1), 128'(LB));
    chk({tag, "_m"}, 128'(b_if.m), 128'(exp));
    chk({tag, "_busy_at_done"}, 128'(b_if.busy), 128'd0);
    chk({tag, "_busy_run"}, 128'(busy_bad), 128'd0);
    extra = 0; moved = 0;
    repeat ((mode == 1) ? 600 : 2) begin
      @(negedge clk);
      if (b_if.done) extra++;
      if (b_if.m !== 16'(exp)) moved++;
    end
    chk({tag, "_single_done"}, 128'(extra), 128'd0);
    chk({tag, "_m_hold"}, 128'(moved), 128'd0);
  endtask

  initial begin
    longint unsigned c_enc;
    logic [15:0] rn;
    rst_a = 1'b0; rst_b = 1'b0;
    a_if.start = 1'b0; a_if.c = '0; a_if.d_key = '0; a_if.n = '0;
    b_if.start = 1'b0; b_if.c = '0; b_if.d_key = '0; b_if.n = '0;
    repeat (2) @(negedge clk);
    chk("rst_a_m", a_if.m, 128'd0);
    chk("rst_a_busy", 128'(a_if.busy), 128'd0);
    chk("rst_a_done", 128'(a_if.done), 128'd0);
    chk("rst_b_m", 128'(b_if.m), 128'd0);
    chk("rst_b_busy", 128'(b_if.busy), 128'd0);
    chk("rst_b_done", 128'(b_if.done), 128'd0);
    rst_a = 1'b1; rst_b = 1'b1;

    fork
      begin
        c_enc = modpow(920, 157, 2773);       // ciphertext from the encrypt side
        op128(c_enc, 17, 2773, "a_rsa920", -1);
        chk("a_rsa920_plain", a_if.m, 128'd920);
        op128(2, 10, 1000, "a_abort", 5000);
        op128(2, 10, 1000, "a_after", -1);
      end
      begin
        op16(16'd2,    16'd10, 16'd1000, 0, "b_2_10_1000");
        op16(16'd2772, 16'd17, 16'd2773, 0, "b_neg1_odd");
        op16(16'd2772, 16'd2,  16'd2773, 0, "b_neg1_even");
        op16(16'd3000, 16'd1,  16'd2773, 0, "b_reduce");
        op16(16'd5,    16'd0,  16'd2773, 0, "b_d0");
        op16(16'd123,  16'd45, 16'd1,    0, "b_n1");
        op16(16'd123,  16'd45, 16'd0,    0, "b_n0");
        op16(16'd0,    16'd7,  16'd2773, 0, "b_c0");
        op16(16'd0,    16'd0,  16'd2773, 0, "b_c0_d0");
        op16(16'd65535, 16'd65535, 16'd65535, 0, "b_max");
        op16(16'd2,    16'd10, 16'd1000, 1, "b_retrig");
        op16(16'd1234, 16'd567, 16'd60001, 2, "b_midchg");
        for (int v = 0; v < 30; v++) begin
          rn = 16'($urandom_range(65535, 2));
          op16(16'($urandom), 16'($urandom), rn, 0, "b_rand");
        end
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/top_level_dec.md
Name: top_level_dec

Overview:
- RSA decryption core, m = c^d mod n. It is the receive-side counterpart of top_level_enc.
- It sits beside the encoder in multiplier_top:
  - takes the 128-bit ciphertext from transceiver64 rx_data and a one-cycle start;
  - returns the plaintext with a one-cycle done that drives tx_wr.
- Implementation is right-to-left square-and-multiply. Each modular product uses interleaved shift-add reduction, one multiplier bit per clock.
- Latency is fixed and data-independent, which makes it constant-time.

Parameters:
- WIDTH, 128, operand width of c, d_key, n and m.

Ports:
- clk      input   1      rising-edge clock (clock_50M in top).
- reset    input   1      asynchronous, active-low reset; 0 clears all state immediately.
- start    input   1      one-cycle request; sampled only in IDLE.
- c        input   WIDTH  ciphertext; any value (reduced mod n internally).
- d_key    input   WIDTH  private exponent.
- n        input   WIDTH  modulus.
- m        output  WIDTH  plaintext; held stable until next done.
- done     output  1      one-cycle pulse; m valid in the same cycle.
- busy     output  1      high from the cycle after start is accepted until done.

Behaviour:
- Reset (reset=0, async): state=IDLE, m=0, done=0, busy=0, all internal registers 0.
- Reset mid-operation aborts the computation. No done is issued and m returns to 0.
- IDLE, start=1 at clock edge:
  - latch c, d_key, n into internal registers;
  - busy=1; result=1; bit index i=0; go to REDUCE.
  - Inputs may change freely after this edge.
- start while busy is ignored. It is not queued.
- Modular product modmul(a,b), WIDTH cycles. Register acc has WIDTH+2 bits. For each bit b[k], k from WIDTH-1 down to 0, one bit per cycle:
  - acc = 2*acc; if acc >= n then acc -= n;
  - if b[k]: acc += a; if acc >= n then acc -= n.
  - Requires a < n. The acc width must hold 2n-1 without overflow.
- REDUCE (WIDTH cycles): base = modmul(1, c), which equals c mod n.
- MUL (WIDTH cycles): tmp = modmul(result, base). Always computed.
  - At the end, result = tmp only if d[i]=1; otherwise result is unchanged.
- SQR (WIDTH cycles): base = modmul(base, base).
- NEXT (1 cycle):
  - if i==WIDTH-1 go to DONE;
  - else i = i+1 and go to MUL.
- DONE (1 cycle): m = result; done=1; busy=0; return to IDLE.
  - start is accepted again on the following edge.
- Latency, from the edge that samples start to the edge where done is high: L = WIDTH + WIDTH*(2*WIDTH+1) + 2.
  - WIDTH=128: L = 33026.
  - WIDTH=16: L = 546.
- Boundary cases. None of them changes latency; only the result value differs.
  - n==0: the product logic is bypassed and m=0.
  - n==1: m=0.
  - d_key==0 with n>=2: m=1.
  - c>=n: handled by REDUCE.
  - c==0: m=0 unless d_key==0.
- done is never asserted in the same cycle as the start that launched the operation.
- done is never asserted twice for one start.

Test Plan:
- WIDTH=128, n=2773, d_key=17. Drive c = top_level_enc(message=920, e_key=157, n=2773) and decrypt. Required: m=920, done exactly 33026 cycles after start, and one cycle wide.
- WIDTH=128, c=2, d_key=10, n=1000 -> m=24. Also c=2772, d_key=17, n=2773 -> m=2772; and c=2772, d_key=2, n=2773 -> m=1.
- WIDTH=128, boundary values:
  - c=3000, d_key=1, n=2773 -> m=227 (reduction path);
  - c=5, d_key=0, n=2773 -> m=1;
  - n=1 -> m=0;
  - n=0 -> m=0.
  - Latency is unchanged in every case.
- WIDTH=16, random c, d_key, n in [2, 65535] checked against a software model over 1000 vectors. Each run must also show busy high only for the operation and done asserted once per start.
- Re-trigger, mid-run input changes, and reset abort:
  - pulse start again at cycle 100 of a run -> ignored, single done.
  - change c, d_key and n mid-run -> m unaffected.
  - drive reset=0 at cycle 5000 -> m=0, busy=0, no done.
  - After release, a new start gives a correct result.
